// File: rtl/csr_exec_unit.sv
// csr_exec_unit: requester-side sequencer for the M-mode CSR file.
// Runs CSRRW/CSRRS/CSRRC, ECALL and MRET as short multi-cycle transactions
// and hands rd writeback plus PC redirect downstream via valid/ready.
// Optional feature macro: CSR_EXEC_ACCESS_CHECK_EN (address/write access fault).

package csr_exec_pkg;
   typedef enum logic [1:0] {
      CSR_WRITE = 2'b00,
      CSR_SET   = 2'b01,
      CSR_CLEAR = 2'b10
   } csr_op_e;
endpackage

module csr_exec_unit
   import csr_exec_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [1:0]      in_kind,
   input  csr_op_e         in_op,
   input  logic [11:0]     in_addr,
   input  logic [XLEN-1:0] in_src,
   input  logic            in_src_zero,
   input  logic [4:0]      in_rd,
   input  logic [XLEN-1:0] in_pc,
   input  logic [XLEN-1:0] in_a5,
   output logic [11:0]     csr_raddr,
   input  logic [XLEN-1:0] csr_rdata,
   output logic            csr_wen,
   output csr_op_e         csr_op,
   output logic [11:0]     csr_waddr,
   output logic [XLEN-1:0] csr_wdata,
   output logic            csr_is_ecall,
   output logic            csr_is_mret,
   output logic [XLEN-1:0] csr_inst_pc,
   output logic [XLEN-1:0] csr_a5,
   input  logic [XLEN-1:0] csr_ecall_target,
   input  logic [XLEN-1:0] csr_mret_target,
   output logic            out_valid,
   input  logic            out_ready,
   output logic            out_rd_wen,
   output logic [4:0]      out_rd,
   output logic [XLEN-1:0] out_rd_data,
   output logic            out_redirect,
   output logic [XLEN-1:0] out_redirect_pc,
   output logic            out_illegal
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_READ  = 3'd1,
      S_WRITE = 3'd2,
      S_TRAP  = 3'd3,
      S_RESP  = 3'd4
   } state_e;

   state_e state, state_nxt;
   logic   live_q;

   logic [1:0]      kind_q;
   csr_op_e         op_q;
   logic [11:0]     addr_q;
   logic [XLEN-1:0] src_q;
   logic            src_zero_q;
   logic [4:0]      rd_q;
   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] a5_q;
   logic [XLEN-1:0] old_q;
   logic [XLEN-1:0] target_q;
   logic            fault;

   logic accept;
   logic wr_attempt;

   assign accept = in_ready && in_valid;
   // SET/CLEAR with a zero source are read-only accesses; WRITE always writes
   assign wr_attempt = !(((op_q == CSR_SET) || (op_q == CSR_CLEAR)) && src_zero_q);

   // State register; live_q keeps in_ready low until the first post-reset cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         live_q <= 1'b0;
      end else begin
         state  <= state_nxt;
         live_q <= 1'b1;
      end
   end

   // Next-state decode
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (accept) begin
               case (in_kind)
                  2'b00:        state_nxt = S_READ;
                  2'b01, 2'b10: state_nxt = S_TRAP;
                  default:      state_nxt = S_RESP;
               endcase
            end
         end
         S_READ:  state_nxt = S_WRITE;
         S_WRITE: state_nxt = S_RESP;
         S_TRAP:  state_nxt = S_RESP;
         S_RESP:  if (out_ready) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Transaction operands and results; outputs are state-gated so no reset needed
   always_ff @(posedge clk) begin
      if (accept) begin
         kind_q     <= in_kind;
         op_q       <= in_op;
         addr_q     <= in_addr;
         src_q      <= in_src;
         src_zero_q <= in_src_zero;
         rd_q       <= in_rd;
         pc_q       <= in_pc;
         a5_q       <= in_a5;
         old_q      <= '0;
         target_q   <= '0;
      end
      if (state == S_READ) old_q <= csr_rdata;
      if (state == S_TRAP) target_q <= (kind_q == 2'b01) ? csr_ecall_target : csr_mret_target;
   end

`ifdef CSR_EXEC_ACCESS_CHECK_EN
   logic fault_q;
   logic addr_known;

   assign addr_known = (addr_q == 12'h300) || (addr_q == 12'h305) ||
                       (addr_q == 12'h341) || (addr_q == 12'h342);

   // Access fault evaluated during READ: unknown CSR, or write to a read-only space
   always_ff @(posedge clk) begin
      if (accept) fault_q <= 1'b0;
      else if (state == S_READ)
         fault_q <= !addr_known || (wr_attempt && (addr_q[11:10] == 2'b11));
   end

   assign fault = fault_q;
`else
   assign fault = 1'b0;
`endif

   // Output decode, driven purely from state so strobes die with reset
   always_comb begin
      in_ready        = (state == S_IDLE) && live_q;
      csr_raddr       = '0;
      csr_wen         = 1'b0;
      csr_op          = CSR_WRITE;
      csr_waddr       = '0;
      csr_wdata       = '0;
      csr_is_ecall    = 1'b0;
      csr_is_mret     = 1'b0;
      csr_inst_pc     = '0;
      csr_a5          = '0;
      out_valid       = 1'b0;
      out_rd_wen      = 1'b0;
      out_rd          = '0;
      out_rd_data     = '0;
      out_redirect    = 1'b0;
      out_redirect_pc = '0;
      out_illegal     = 1'b0;
      case (state)
         S_READ: csr_raddr = addr_q;
         S_WRITE: begin
            csr_waddr = addr_q;
            csr_op    = op_q;
            csr_wdata = src_q;
            csr_wen   = wr_attempt && !fault;
         end
         S_TRAP: begin
            csr_is_ecall = (kind_q == 2'b01);
            csr_is_mret  = (kind_q == 2'b10);
            csr_inst_pc  = pc_q;
            csr_a5       = a5_q;
         end
         S_RESP: begin
            out_valid       = 1'b1;
            out_rd_wen      = (kind_q == 2'b00) && (rd_q != 5'd0) && !fault;
            out_rd          = rd_q;
            out_rd_data     = old_q;
            out_redirect    = (kind_q == 2'b01) || (kind_q == 2'b10);
            out_redirect_pc = target_q;
            out_illegal     = fault;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_csr_exec_unit.sv
// Testbench for csr_exec_unit: table-driven transactions against a small
// CSR-file stub, plus hand sequences for reset, back-pressure and reset mid-WRITE.
module tb_csr_exec_unit;
   import csr_exec_pkg::*;
   localparam int XLEN = 32;

   logic            clk;
   logic            rst_n;
   logic            in_valid;
   logic            in_ready;
   logic [1:0]      in_kind;
   csr_op_e         in_op;
   logic [11:0]     in_addr;
   logic [XLEN-1:0] in_src;
   logic            in_src_zero;
   logic [4:0]      in_rd;
   logic [XLEN-1:0] in_pc;
   logic [XLEN-1:0] in_a5;
   logic [11:0]     csr_raddr;
   logic [XLEN-1:0] csr_rdata;
   logic            csr_wen;
   csr_op_e         csr_op;
   logic [11:0]     csr_waddr;
   logic [XLEN-1:0] csr_wdata;
   logic            csr_is_ecall;
   logic            csr_is_mret;
   logic [XLEN-1:0] csr_inst_pc;
   logic [XLEN-1:0] csr_a5;
   logic [XLEN-1:0] csr_ecall_target;
   logic [XLEN-1:0] csr_mret_target;
   logic            out_valid;
   logic            out_ready;
   logic            out_rd_wen;
   logic [4:0]      out_rd;
   logic [XLEN-1:0] out_rd_data;
   logic            out_redirect;
   logic [XLEN-1:0] out_redirect_pc;
   logic            out_illegal;

   csr_exec_unit #(.XLEN(XLEN)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind), .in_op(in_op),
      .in_addr(in_addr), .in_src(in_src), .in_src_zero(in_src_zero), .in_rd(in_rd),
      .in_pc(in_pc), .in_a5(in_a5),
      .csr_raddr(csr_raddr), .csr_rdata(csr_rdata), .csr_wen(csr_wen), .csr_op(csr_op),
      .csr_waddr(csr_waddr), .csr_wdata(csr_wdata), .csr_is_ecall(csr_is_ecall),
      .csr_is_mret(csr_is_mret), .csr_inst_pc(csr_inst_pc), .csr_a5(csr_a5),
      .csr_ecall_target(csr_ecall_target), .csr_mret_target(csr_mret_target),
      .out_valid(out_valid), .out_ready(out_ready), .out_rd_wen(out_rd_wen),
      .out_rd(out_rd), .out_rd_data(out_rd_data), .out_redirect(out_redirect),
      .out_redirect_pc(out_redirect_pc), .out_illegal(out_illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // CSR file stub: mstatus resets to 0x1800, others to 0, unknown reads as 0
   logic [31:0] m_mstatus = 32'h0000_1800;
   logic [31:0] m_mtvec   = 32'h0;
   logic [31:0] m_mepc    = 32'h0;
   logic [31:0] m_mcause  = 32'h0;

   always_comb begin
      case (csr_raddr)
         12'h300: csr_rdata = m_mstatus;
         12'h305: csr_rdata = m_mtvec;
         12'h341: csr_rdata = m_mepc;
         12'h342: csr_rdata = m_mcause;
         default: csr_rdata = 32'h0;
      endcase
   end
   assign csr_ecall_target = m_mtvec;
   assign csr_mret_target  = m_mepc;

   function automatic logic [31:0] csr_apply(input logic [31:0] old, input csr_op_e op,
                                             input logic [31:0] wd);
      case (op)
         CSR_SET:   return old | wd;
         CSR_CLEAR: return old & ~wd;
         default:   return wd;
      endcase
   endfunction

   int          n_wen = 0, n_ecall = 0, n_mret = 0;
   logic [31:0] last_wdata = '0, last_pc = '0, last_a5 = '0;
   csr_op_e     last_op = CSR_WRITE;

   // Monitor on the falling edge: counts strobes and applies writes to the stub
   always @(negedge clk) begin
      if (rst_n) begin
         if (csr_wen) begin
            n_wen++;
            last_wdata = csr_wdata;
            last_op    = csr_op;
            case (csr_waddr)
               12'h300: m_mstatus = csr_apply(m_mstatus, csr_op, csr_wdata);
               12'h305: m_mtvec   = csr_apply(m_mtvec, csr_op, csr_wdata);
               12'h341: m_mepc    = csr_apply(m_mepc, csr_op, csr_wdata);
               12'h342: m_mcause  = csr_apply(m_mcause, csr_op, csr_wdata);
               default: ;
            endcase
         end
         if (csr_is_ecall) begin
            n_ecall++;
            last_pc = csr_inst_pc;
            last_a5 = csr_a5;
         end
         if (csr_is_mret) n_mret++;
      end
   end

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [1:0]  kind;
      csr_op_e     op;
      logic [11:0] addr;
      logic [31:0] src;
      logic        zero;
      logic [4:0]  rd;
      logic [31:0] pc;
      logic [31:0] a5;
      int          lat;
      logic        rd_wen;
      logic [31:0] rd_data;
      logic        redir;
      logic [31:0] rpc;
      int          nwen;
      int          nact;
      logic        ill;
   } vec_t;

   function automatic vec_t mk(input logic [1:0] kind, input csr_op_e op, input logic [11:0] addr,
                               input logic [31:0] src, input logic zero, input logic [4:0] rd,
                               input logic [31:0] pc, input logic [31:0] a5, input int lat,
                               input logic rd_wen, input logic [31:0] rd_data, input logic redir,
                               input logic [31:0] rpc, input int nwen, input int nact,
                               input logic ill);
      vec_t v;
      v.kind = kind; v.op = op; v.addr = addr; v.src = src; v.zero = zero; v.rd = rd;
      v.pc = pc; v.a5 = a5; v.lat = lat; v.rd_wen = rd_wen; v.rd_data = rd_data;
      v.redir = redir; v.rpc = rpc; v.nwen = nwen; v.nact = nact; v.ill = ill;
      return v;
   endfunction

   task automatic drive(input vec_t t);
      in_kind     = t.kind;
      in_op       = t.op;
      in_addr     = t.addr;
      in_src      = t.src;
      in_src_zero = t.zero;
      in_rd       = t.rd;
      in_pc       = t.pc;
      in_a5       = t.a5;
   endtask

   task automatic run(input vec_t t, input string tag);
      int b_wen, b_ec, b_mr, lat;
      @(negedge clk);
      chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
      drive(t);
      in_valid  = 1'b1;
      out_ready = 1'b0;
      b_wen = n_wen; b_ec = n_ecall; b_mr = n_mret;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, ".latency"}, 32'(lat), 32'(t.lat));
      chk({tag, ".rd_wen"}, 32'(out_rd_wen), 32'(t.rd_wen));
      chk({tag, ".rd"}, 32'(out_rd), 32'(t.rd));
      if (t.kind == 2'b00) chk({tag, ".rd_data"}, out_rd_data, t.rd_data);
      chk({tag, ".redirect"}, 32'(out_redirect), 32'(t.redir));
      if (t.redir) chk({tag, ".redirect_pc"}, out_redirect_pc, t.rpc);
      chk({tag, ".illegal"}, 32'(out_illegal), 32'(t.ill));
      chk({tag, ".wen_cycles"}, 32'(n_wen - b_wen), 32'(t.nwen));
      if (t.nwen > 0) begin
         chk({tag, ".wdata"}, last_wdata, t.src);
         chk({tag, ".wop"}, 32'(last_op), 32'(t.op));
      end
      chk({tag, ".actions"}, 32'((n_ecall - b_ec) + (n_mret - b_mr)), 32'(t.nact));
      if (t.kind == 2'b01) begin
         chk({tag, ".ecall_pulses"}, 32'(n_ecall - b_ec), 32'd1);
         chk({tag, ".inst_pc"}, last_pc, t.pc);
         chk({tag, ".a5"}, last_a5, t.a5);
      end
      if (t.kind == 2'b10) chk({tag, ".mret_pulses"}, 32'(n_mret - b_mr), 32'd1);
      chk({tag, ".in_ready_busy"}, 32'(in_ready), 32'd0);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({tag, ".valid_drop"}, 32'(out_valid), 32'd0);
      chk({tag, ".back_idle"}, 32'(in_ready), 32'd1);
   endtask

   vec_t vt[11];

   initial begin
      int b_wen, seen;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_kind = 2'b00; in_op = CSR_WRITE; in_addr = '0; in_src = '0;
      in_src_zero = 1'b0; in_rd = '0; in_pc = '0; in_a5 = '0;

      // kind op addr src zero rd pc a5 | lat rd_wen rd_data redir rpc nwen nact ill
      vt[0]  = mk(2'b00, CSR_WRITE, 12'h305, 32'h8000_0100, 1'b0, 5'd5, 0, 0, 2, 1'b1, 32'h0,    1'b0, 0, 1, 0, 1'b0);
      vt[1]  = mk(2'b00, CSR_SET,   12'h300, 32'h0,         1'b1, 5'd6, 0, 0, 2, 1'b1, 32'h1800, 1'b0, 0, 0, 0, 1'b0);
      vt[2]  = mk(2'b01, CSR_WRITE, 12'h000, 32'h0,         1'b0, 5'd0, 32'h8000_0040, 32'hB, 1, 1'b0, 32'h0, 1'b1, 32'h8000_0100, 0, 1, 1'b0);
      vt[3]  = mk(2'b00, CSR_WRITE, 12'h341, 32'h8000_0044, 1'b0, 5'd0, 0, 0, 2, 1'b0, 32'h0,    1'b0, 0, 1, 0, 1'b0);
      vt[4]  = mk(2'b10, CSR_WRITE, 12'h000, 32'h0,         1'b0, 5'd0, 32'h8000_0050, 32'h0, 1, 1'b0, 32'h0, 1'b1, 32'h8000_0044, 0, 1, 1'b0);
      vt[5]  = mk(2'b00, CSR_SET,   12'h300, 32'h8,         1'b0, 5'd7, 0, 0, 2, 1'b1, 32'h1800, 1'b0, 0, 1, 0, 1'b0);
      vt[6]  = mk(2'b00, CSR_CLEAR, 12'h300, 32'h1000,      1'b0, 5'd8, 0, 0, 2, 1'b1, 32'h1808, 1'b0, 0, 1, 0, 1'b0);
      vt[7]  = mk(2'b00, CSR_WRITE, 12'h300, 32'h0,         1'b1, 5'd9, 0, 0, 2, 1'b1, 32'h0808, 1'b0, 0, 1, 0, 1'b0);
      vt[8]  = mk(2'b00, CSR_CLEAR, 12'h300, 32'h0,         1'b1, 5'd10, 0, 0, 2, 1'b1, 32'h0,   1'b0, 0, 0, 0, 1'b0);
      vt[9]  = mk(2'b11, CSR_WRITE, 12'h300, 32'h5,         1'b0, 5'd11, 0, 0, 0, 1'b0, 32'h0,   1'b0, 0, 0, 0, 1'b0);
`ifdef CSR_EXEC_ACCESS_CHECK_EN
      vt[10] = mk(2'b00, CSR_WRITE, 12'hC00, 32'h1234,      1'b0, 5'd15, 0, 0, 2, 1'b0, 32'h0,   1'b0, 0, 0, 0, 1'b1);
`else
      vt[10] = mk(2'b00, CSR_WRITE, 12'hC00, 32'h1234,      1'b0, 5'd15, 0, 0, 2, 1'b1, 32'h0,   1'b0, 0, 1, 0, 1'b0);
`endif

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst.in_ready", 32'(in_ready), 32'd0);
      chk("rst.out_valid", 32'(out_valid), 32'd0);
      chk("rst.csr_wen", 32'(csr_wen), 32'd0);
      chk("rst.redirect_pc", out_redirect_pc, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst.in_ready_before_edge", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      chk("rst.in_ready_after", 32'(in_ready), 32'd1);

      for (int i = 0; i < 11; i++) run(vt[i], $sformatf("v%0d", i));

      // Back-pressure: CSRRS read of mtvec held in RESP for 5 cycles
      @(negedge clk);
      in_kind = 2'b00; in_op = CSR_SET; in_addr = 12'h305; in_src = 32'h0;
      in_src_zero = 1'b1; in_rd = 5'd13; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      for (int c = 0; c < 5; c++) begin
         chk($sformatf("bp%0d.out_valid", c), 32'(out_valid), 32'd1);
         chk($sformatf("bp%0d.rd_data", c), out_rd_data, 32'h8000_0100);
         chk($sformatf("bp%0d.rd", c), 32'(out_rd), 32'd13);
         chk($sformatf("bp%0d.in_ready", c), 32'(in_ready), 32'd0);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("bp.valid_drop", 32'(out_valid), 32'd0);
      chk("bp.idle", 32'(in_ready), 32'd1);

      // Reset asserted during WRITE: strobe drops at once, no response follows
      @(negedge clk);
      in_kind = 2'b00; in_op = CSR_WRITE; in_addr = 12'h342; in_src = 32'h55;
      in_src_zero = 1'b0; in_rd = 5'd14; in_valid = 1'b1;
      b_wen = n_wen;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      chk("mid.wen_in_write", 32'(csr_wen), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("mid.wen_dropped", 32'(csr_wen), 32'd0);
      chk("mid.in_ready_rst", 32'(in_ready), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      chk("mid.no_response", 32'(seen), 32'd0);
      chk("mid.no_write", 32'(n_wen - b_wen), 32'd0);
      chk("mid.idle", 32'(in_ready), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Global time limit so the run always ends
   initial begin
      #200000;
      $display("FAIL timeout: got running want finished");
      $fatal(1, "time limit");
   end

endmodule

// File: doc/csr_exec_unit.md
# csr_exec_unit

Requester-side sequencer for the M-mode CSR file. It sits in the EXU between the IDU handshake and the CSR file's read/write/action ports. It executes CSRRW/CSRRS/CSRRC (register and immediate forms), ECALL and MRET as short multi-cycle transactions, then hands rd writeback and PC redirect downstream with a valid/ready handshake. It is the initiator for the CSR file's `raddr/rdata`, `wen/op/waddr/wdata`, `is_ecall/is_mret`, `ecall_target/mret_target` interface.

## Interface
- XLEN, 32, datapath width
- clk  in  1  clock, rising edge
- rst_n  in  1  reset; one clock, asynchronous assertion, active-low
- in_valid / in_ready  in / out  1  upstream handshake
- in_kind  in  2  00 CSRRx, 01 ECALL, 10 MRET, 11 reserved
- in_op  in  csr_op_e  CSR_WRITE / CSR_SET / CSR_CLEAR
- in_addr  in  12  CSR address
- in_src  in  XLEN  rs1 value or zero-extended uimm
- in_src_zero  in  1  rs1 index is x0 or uimm is 0
- in_rd  in  5  destination register
- in_pc, in_a5  in  XLEN  instruction PC; a5 value
- csr_raddr  out  12  CSR read address
- csr_rdata  in  XLEN  CSR read data
- csr_wen  out  1  CSR write enable
- csr_op  out  csr_op_e  CSR write operation
- csr_waddr  out  12  CSR write address
- csr_wdata  out  XLEN  CSR write data
- csr_is_ecall, csr_is_mret  out  1  action pulses
- csr_inst_pc, csr_a5  out  XLEN  action operands
- csr_ecall_target, csr_mret_target  in  XLEN  redirect sources
- out_valid / out_ready  out / in  1  downstream handshake
- out_rd_wen  out  1  rd writeback enable
- out_rd  out  5  rd index
- out_rd_data  out  XLEN  rd writeback data
- out_redirect  out  1  PC redirect request
- out_redirect_pc  out  XLEN  redirect target
- out_illegal  out  1  access fault (see Configuration)

## Operation
- FSM states:
  - IDLE: in_ready=1. On in_valid, latch all in_* fields.
    - kind 00: go to READ.
    - kind 01/10: go to TRAP.
    - kind 11: go to RESP with no effects.
  - READ: csr_raddr=addr_q. At cycle end, sample csr_rdata into old_q. Go to WRITE.
  - WRITE:
    - Drive csr_waddr=addr_q, csr_op=op_q, csr_wdata=src_q.
    - csr_wen=1, except when op_q is SET or CLEAR and src_zero_q=1; then no write.
    - CSR_WRITE with src_zero_q=1 still writes 0.
    - Go to RESP.
  - TRAP:
    - Pulse csr_is_ecall (kind 01) or csr_is_mret (kind 10) for exactly one cycle.
    - csr_inst_pc=pc_q, csr_a5=a5_q.
    - Sample csr_ecall_target or csr_mret_target into target_q in the same cycle; these are pre-edge values, and mtvec/mepc are unchanged by the action.
    - Go to RESP.
  - RESP: out_valid=1. Fields stay stable until out_ready. On handshake, go to IDLE.
- Response fields:
  - out_rd_wen = (kind_q==00) && rd_q!=0.
  - out_rd_data = old_q.
  - out_redirect = kind_q is 01 or 10; out_redirect_pc = target_q.
- All CSR-side strobes (csr_wen, csr_is_ecall, csr_is_mret) are decoded from state only, never from in_valid.

## Timing
- Accept on edge E:
  - CSRRx: READ in cycle E+1, WRITE in E+2, out_valid from E+3.
  - ECALL/MRET: TRAP in E+1, out_valid from E+2.
  - Reserved kind: out_valid from E+1.
- in_ready=0 in every state except IDLE, so at most one transaction is in flight.
- Back-pressure: if out_ready=0, hold RESP indefinitely with all outputs constant.
- Reset values: all outputs 0 and state IDLE. During reset, in_ready=0; it rises to 1 on the first cycle after rst_n deasserts.
- Reset mid-transaction: csr_wen and the action pulses drop immediately (asynchronous) and the transaction is discarded with no response.

## Configuration
- CSR_EXEC_ACCESS_CHECK_EN defined:
  - In READ, addresses outside {0x300, 0x305, 0x341, 0x342} set a fault flag.
  - A write attempt to addr[11:10]==2'b11 also sets the fault flag.
  - On fault: WRITE issues no csr_wen, out_rd_wen=0, and RESP asserts out_illegal=1.
- Undefined: no check; out_illegal is tied to 0, and unknown addresses read the CSR file's default value of 0.

## Test plan
- CSRRW rd=5, addr 0x305, src 0x80000100 with prior mtvec 0 -> rd_data 0, one csr_wen cycle with wdata 0x80000100, out_valid at E+3.
- CSRRS addr 0x300, src_zero=1, rd=6 -> rd_data 0x1800 after reset, csr_wen never asserted.
- ECALL pc 0x80000040, a5 0xB, mtvec 0x80000100 -> single csr_is_ecall pulse with inst_pc/a5 driven, out_redirect=1, redirect_pc 0x80000100, out_rd_wen=0.
- MRET with mepc 0x80000044 -> single csr_is_mret pulse, redirect_pc 0x80000044.
- out_ready held 0 for 5 cycles in RESP -> outputs stable, in_ready=0 throughout; handshake then IDLE.
- rst_n asserted during WRITE -> csr_wen drops the same cycle, no out_valid; with CSR_EXEC_ACCESS_CHECK_EN, CSRRW to 0xC00 -> out_illegal=1, no write.
